apu_serial_rx: RTL

Serial front end for the APU sound core: receives 8N1 UART bytes on the host RX line and decodes two-byte frames into APU register writes (address 0x00–0x1F, data 0x00–0xFF). It sits directly upstream of the APU register file and provides the RX activity (`link`) status driven to the top-level status pin. It is clocked by the system oscillator, not by the APU clock.

---
 rtl/apu_serial_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/apu_serial_rx.sv
// UART 8N1 receiver that turns two-byte host frames (address 0x80|idx, then data)
// into one-clock APU register write strobes, plus RX activity and error pulses.
module apu_serial_rx #(
  parameter int OSCRATE  = 12_000_000,
  parameter int BAUDRATE = 9600,
  parameter int LINKTIME = OSCRATE / 10,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       reg_wr,
  output logic       link,
  output logic       frame_err,
  output logic       sync_err
);

  localparam int BITDIV  = OSCRATE / BAUDRATE;
  localparam int DIV_W   = $clog2(BITDIV + 1);
  localparam int TMO_CYC = TIMEOUT * BITDIV;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);
  localparam int LINK_W  = $clog2(LINKTIME + 1);

  // Divider counts down to zero, so loads are one less than the period.
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BITDIV / 2 - 1);
  localparam logic [DIV_W-1:0]  DIV_FULL  = DIV_W'(BITDIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TMO_CYC);
  localparam logic [LINK_W-1:0] LINK_LOAD = LINK_W'(LINKTIME);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
  typedef enum logic {WAIT_ADDR, WAIT_DATA} frame_state_t;

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  logic start_edge;
  assign start_edge = rx_prev & ~rx_sync;

  bit_state_t       bit_state, bit_state_next;
  logic [DIV_W-1:0] div, div_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shift, shift_next;
  logic             div_done;
  logic             byte_done;
  logic             stop_ok;

  assign div_done = (div == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_state <= IDLE;
      div       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      bit_state <= bit_state_next;
      div       <= div_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
    end
  end

  always_comb begin
    bit_state_next = bit_state;
    div_next       = div;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    byte_done      = 1'b0;
    stop_ok        = 1'b0;
    case (bit_state)
      IDLE: begin
        if (start_edge) begin
          bit_state_next = START;
          div_next       = DIV_HALF;
        end
      end
      START: begin
        if (!div_done) begin
          div_next = div - DIV_W'(1);
        end else if (!rx_sync) begin
          bit_state_next = DATA;
          div_next       = DIV_FULL;
          bit_cnt_next   = '0;
        end else begin
          bit_state_next = IDLE;
        end
      end
      DATA: begin
        if (!div_done) begin
          div_next = div - DIV_W'(1);
        end else begin
          shift_next   = {rx_sync, shift[7:1]};
          div_next     = DIV_FULL;
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) bit_state_next = STOP;
        end
      end
      STOP: begin
        if (!div_done) begin
          div_next = div - DIV_W'(1);
        end else begin
          // Return to IDLE on the sample itself so a back-to-back start edge is not missed.
          byte_done      = 1'b1;
          stop_ok        = rx_sync;
          bit_state_next = IDLE;
        end
      end
      default: bit_state_next = IDLE;
    endcase
  end

  frame_state_t     frame_state, frame_state_next;
  logic [4:0]       pend_addr, pend_addr_next;
  logic [TMO_W-1:0] tmo, tmo_next;
  logic [4:0]       reg_addr_next;
  logic [7:0]       reg_data_next;
  logic             reg_wr_next, frame_err_next, sync_err_next;
  logic [LINK_W-1:0] link_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state <= WAIT_ADDR;
      pend_addr   <= '0;
      tmo         <= '0;
      reg_addr    <= '0;
      reg_data    <= '0;
      reg_wr      <= 1'b0;
      frame_err   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_state <= frame_state_next;
      pend_addr   <= pend_addr_next;
      tmo         <= tmo_next;
      reg_addr    <= reg_addr_next;
      reg_data    <= reg_data_next;
      reg_wr      <= reg_wr_next;
      frame_err   <= frame_err_next;
      sync_err    <= sync_err_next;
    end
  end

  always_comb begin
    frame_state_next = frame_state;
    pend_addr_next   = pend_addr;
    tmo_next         = tmo;
    reg_addr_next    = reg_addr;
    reg_data_next    = reg_data;
    reg_wr_next      = 1'b0;
    frame_err_next   = 1'b0;
    sync_err_next    = 1'b0;
    if (byte_done && !stop_ok) begin
      frame_err_next   = 1'b1;
      frame_state_next = WAIT_ADDR;
    end else if (byte_done) begin
      if (frame_state == WAIT_ADDR) begin
        if (shift[7:5] == 3'b100) begin
          pend_addr_next   = shift[4:0];
          tmo_next         = TMO_LOAD;
          frame_state_next = WAIT_DATA;
        end else begin
          sync_err_next = 1'b1;
        end
      end else begin
        reg_addr_next    = pend_addr;
        reg_data_next    = shift;
        reg_wr_next      = 1'b1;
        frame_state_next = WAIT_ADDR;
      end
    end else if (frame_state == WAIT_DATA && bit_state == IDLE && !start_edge) begin
      // Timeout only runs while the line is quiet; a start edge freezes it.
      if (tmo == '0) frame_state_next = WAIT_ADDR;
      else           tmo_next = tmo - TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_cnt <= '0;
    end else if (byte_done && stop_ok) begin
      link_cnt <= LINK_LOAD;
    end else if (link_cnt != '0) begin
      link_cnt <= link_cnt - LINK_W'(1);
    end
  end

  assign link = (link_cnt != '0);

endmodule
